exmem_dbus_reg: RTL and testbench
=================================

Name: exmem_dbus_reg

Overview:
EX→MEM pipeline register with the data-side SRAM-like bus master (req/addr_ok/data_ok) for the LoongArch pipeline.
- Latches the EX-stage bundle and issues at most one load/store.
- Captures the returned data.
- Presents the instruction to the MEM stage only after its access completes.
- On exception flush, discards a pending response cleanly.

Parameters:
PAYLOAD_W, 256, width of the opaque EX→MEM bundle passed through unchanged
DATA_W, 32, data bus width
ADDR_W, 32, data address width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ex_to_mem_valid_i  input  1  EX has an instruction to hand over
ex_allowin_o  output  1  register can accept from EX this cycle
excep_flush_i  input  1  exception flush; kills held and incoming instruction
ex_payload_i  input  PAYLOAD_W  EX→MEM bundle
ex_mem_req_i  input  1  instruction performs a memory access
ex_mem_we_i  input  4  byte write strobes; nonzero = store
ex_mem_addr_i  input  ADDR_W  access address
ex_mem_wdata_i  input  DATA_W  store data
ex_excep_en_i  input  1  instruction already carries an exception
data_req_o  output  1  bus request
data_wr_o  output  1  1 = write
data_wstrb_o  output  4  byte strobes
data_addr_o  output  ADDR_W  bus address
data_wdata_o  output  DATA_W  bus write data
data_addr_ok_i  input  1  request accepted
data_data_ok_i  input  1  response valid
data_rdata_i  input  DATA_W  response data
mem_allowin_i  input  1  MEM can accept
mem_valid_o  output  1  valid instruction for MEM
exmem_payload_o  output  PAYLOAD_W  latched bundle
mem_rdata_o  output  DATA_W  captured load data (raw word)

Behaviour:
- Reset (async, rst_n=0): state EMPTY, cancel_q=0. All registered outputs are 0: payload, address, wdata, strobes, rdata. data_req_o=0, mem_valid_o=0, ex_allowin_o=1.
- States:
  - EMPTY: no instruction held.
  - REQ: driving data_req_o.
  - WAIT: accepted, awaiting data_ok.
  - READY: complete; mem_valid_o=1.
- Definitions:
  - ready = (state==READY).
  - ex_allowin_o = (state==EMPTY) | (ready & mem_allowin_i). Combinational.
  - mem_valid_o = ready.
- Load (ex_to_mem_valid_i & ex_allowin_o & !excep_flush_i):
  - Latch the bundle, access fields and wr = |ex_mem_we_i.
  - Next state is REQ if ex_mem_req_i & !ex_excep_en_i, else READY.
  - Otherwise, if ready & mem_allowin_i, next state is EMPTY.
- REQ:
  - data_req_o = !cancel_q.
  - Address, wr, strobes and wdata are held stable from registers.
  - data_addr_ok_i & data_req_o → WAIT.
- WAIT: data_data_ok_i → READY; capture data_rdata_i into mem_rdata_o. Stores also wait for data_ok.
- READY: mem_rdata_o and payload are held stable while mem_allowin_i=0.
- Outstanding limit: one request. addr_ok never coincides with the data_ok of the same request.
- Flush (excep_flush_i=1), any state → EMPTY; the incoming instruction is not latched.
  - If state==WAIT and data_data_ok_i=0: set cancel_q.
  - If state==REQ and addr_ok arrives the same cycle: set cancel_q.
  - If state==REQ and no addr_ok: the request is withdrawn next cycle; cancel_q is not set.
  - If data_ok arrives in the flush cycle: the response is consumed and cancel_q stays 0.
- cancel_q:
  - While set, a later instruction may enter REQ, but data_req_o is held 0.
  - The next data_data_ok_i clears cancel_q; its data is discarded (mem_rdata_o unchanged).
- Latency (minimum):
  - No-access instruction: mem_valid_o in the cycle after entry.
  - Load with addr_ok in the first REQ cycle and data_ok one cycle later: entry at edge T, req in cycle T, WAIT in T+1, mem_valid_o in T+2.
- Throughput: back-to-back non-memory instructions at 1 per cycle with mem_allowin_i=1.

Test Plan:
- Load to 0x0000_1000 with wstrb 0; addr_ok after 2 req cycles; data_ok 3 cycles later with 0xDEADBEEF → data_req_o high for 2 cycles with addr 0x1000 and wr=0. mem_valid_o rises the cycle after data_ok with mem_rdata_o=0xDEADBEEF. ex_allowin_o=0 throughout.
- Five back-to-back non-memory instructions with mem_allowin_i=1 → data_req_o never high; mem_valid_o=1 for five consecutive cycles, with payloads in order.
- Load with ex_excep_en_i=1 → no data_req_o; mem_valid_o the next cycle.
- Load accepted (in WAIT), then flush; next load (addr 0x2000) enters next cycle; stale data_ok with 0x11111111, then new response 0x22222222 → data_req_o stays 0 until the stale data_ok. mem_rdata_o never shows 0x11111111. The second load is delivered with 0x22222222.
- Flush in REQ with no addr_ok → data_req_o low the next cycle; cancel_q=0; a following store (wstrb 4'b0011, wdata 0xABCD) requests immediately with data_wr_o=1.
- READY with mem_allowin_i=0 for 3 cycles → mem_valid_o, payload and rdata held stable, ex_allowin_o=0. Separately, assert rst_n=0 mid-WAIT → all outputs 0 immediately, and a following data_ok is ignored.

Source files
------------

// File: rtl/exmem_dbus_reg.sv
// EX->MEM pipeline register that also acts as the data-side SRAM-like bus master.
// Holds one instruction, issues at most one access and releases it to MEM once the access completes.
module exmem_dbus_reg #(
    parameter int PAYLOAD_W = 256,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_to_mem_valid_i,
    output logic                 ex_allowin_o,
    input  logic                 excep_flush_i,
    input  logic [PAYLOAD_W-1:0] ex_payload_i,
    input  logic                 ex_mem_req_i,
    input  logic [3:0]           ex_mem_we_i,
    input  logic [ADDR_W-1:0]    ex_mem_addr_i,
    input  logic [DATA_W-1:0]    ex_mem_wdata_i,
    input  logic                 ex_excep_en_i,
    output logic                 data_req_o,
    output logic                 data_wr_o,
    output logic [3:0]           data_wstrb_o,
    output logic [ADDR_W-1:0]    data_addr_o,
    output logic [DATA_W-1:0]    data_wdata_o,
    input  logic                 data_addr_ok_i,
    input  logic                 data_data_ok_i,
    input  logic [DATA_W-1:0]    data_rdata_i,
    input  logic                 mem_allowin_i,
    output logic                 mem_valid_o,
    output logic [PAYLOAD_W-1:0] exmem_payload_o,
    output logic [DATA_W-1:0]    mem_rdata_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        READY = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 cancel_q, cancel_d;
    logic                 load;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [3:0]           wstrb_q;
    logic                 wr_q;

    assign load = ex_to_mem_valid_i & ex_allowin_o & ~excep_flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (excep_flush_i) begin
            state_d = EMPTY;
        end else if (load) begin
            state_d = (ex_mem_req_i & ~ex_excep_en_i) ? REQ : READY;
        end else begin
            case (state_q)
                REQ:     if (data_req_o & data_addr_ok_i) state_d = WAIT;
                WAIT:    if (data_data_ok_i) state_d = READY;
                READY:   if (mem_allowin_i) state_d = EMPTY;
                default: state_d = state_q;
            endcase
        end
    end

    // A flushed access that the bus has already accepted still owes us one data_ok;
    // cancel_q swallows it so it cannot be mistaken for the next instruction's response.
    always_comb begin
        cancel_d = cancel_q;
        if (cancel_q & data_data_ok_i) begin
            cancel_d = 1'b0;
        end
        if (excep_flush_i &
            (((state_q == WAIT) & ~data_data_ok_i) |
             ((state_q == REQ) & data_req_o & data_addr_ok_i))) begin
            cancel_d = 1'b1;
        end
    end

    always_comb begin
        ex_allowin_o = (state_q == EMPTY) | ((state_q == READY) & mem_allowin_i);
        data_req_o   = (state_q == REQ) & ~cancel_q;
        mem_valid_o  = (state_q == READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (load) begin
                payload_q <= ex_payload_i;
                addr_q    <= ex_mem_addr_i;
                wdata_q   <= ex_mem_wdata_i;
                wstrb_q   <= ex_mem_we_i;
                wr_q      <= |ex_mem_we_i;
            end
            if ((state_q == WAIT) & data_data_ok_i & ~cancel_q & ~excep_flush_i) begin
                rdata_q <= data_rdata_i;
            end
        end
    end

    assign data_wr_o       = wr_q;
    assign data_wstrb_o    = wstrb_q;
    assign data_addr_o     = addr_q;
    assign data_wdata_o    = wdata_q;
    assign exmem_payload_o = payload_q;
    assign mem_rdata_o     = rdata_q;

endmodule

// File: tb/tb_exmem_dbus_reg.sv
// Directed bench for exmem_dbus_reg: a scoreboard of instructions expected at MEM
// plus immediate checks of the bus handshake at each step.
module tb_exmem_dbus_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ex_to_mem_valid_i;
    logic         ex_allowin_o;
    logic         excep_flush_i;
    logic [255:0] ex_payload_i;
    logic         ex_mem_req_i;
    logic [3:0]   ex_mem_we_i;
    logic [31:0]  ex_mem_addr_i;
    logic [31:0]  ex_mem_wdata_i;
    logic         ex_excep_en_i;
    logic         data_req_o;
    logic         data_wr_o;
    logic [3:0]   data_wstrb_o;
    logic [31:0]  data_addr_o;
    logic [31:0]  data_wdata_o;
    logic         data_addr_ok_i;
    logic         data_data_ok_i;
    logic [31:0]  data_rdata_i;
    logic         mem_allowin_i;
    logic         mem_valid_o;
    logic [255:0] exmem_payload_o;
    logic [31:0]  mem_rdata_o;

    typedef struct {
        logic [255:0] payload;
        logic [31:0]  rdata;
        bit           chk_rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    exmem_dbus_reg dut (
        .clk(clk), .rst_n(rst_n),
        .ex_to_mem_valid_i(ex_to_mem_valid_i), .ex_allowin_o(ex_allowin_o),
        .excep_flush_i(excep_flush_i), .ex_payload_i(ex_payload_i),
        .ex_mem_req_i(ex_mem_req_i), .ex_mem_we_i(ex_mem_we_i),
        .ex_mem_addr_i(ex_mem_addr_i), .ex_mem_wdata_i(ex_mem_wdata_i),
        .ex_excep_en_i(ex_excep_en_i),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_wstrb_o(data_wstrb_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
        .data_rdata_i(data_rdata_i),
        .mem_allowin_i(mem_allowin_i), .mem_valid_o(mem_valid_o),
        .exmem_payload_o(exmem_payload_o), .mem_rdata_o(mem_rdata_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one EX instruction for the current cycle; caller deasserts after the edge.
    task automatic apply_stimulus(input logic [255:0] payload, input logic req, input logic [3:0] we,
                                  input logic [31:0] addr, input logic [31:0] wdata, input logic excep);
        ex_to_mem_valid_i = 1'b1;
        ex_payload_i      = payload;
        ex_mem_req_i      = req;
        ex_mem_we_i       = we;
        ex_mem_addr_i     = addr;
        ex_mem_wdata_i    = wdata;
        ex_excep_en_i     = excep;
    endtask

    task automatic idle_ex();
        ex_to_mem_valid_i = 1'b0;
        ex_mem_req_i      = 1'b0;
        ex_mem_we_i       = 4'd0;
        ex_excep_en_i     = 1'b0;
    endtask

    function automatic exp_t mk(input logic [255:0] p, input logic [31:0] r, input bit c);
        exp_t e;
        e.payload   = p;
        e.rdata     = r;
        e.chk_rdata = c;
        return e;
    endfunction

    // MEM-side consumer: every handoff must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && mem_valid_o && mem_allowin_i) begin
            if (sb.size() == 0) begin
                check_output("unexpected_handoff", {255'd0, mem_valid_o}, 256'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("sb_payload", exmem_payload_o, e.payload);
                if (e.chk_rdata) check_output("sb_rdata", {224'd0, mem_rdata_o}, {224'd0, e.rdata});
            end
        end
    end

    initial begin
        logic [255:0] p;
        logic [31:0]  k;

        rst_n = 1'b0;
        excep_flush_i = 1'b0;
        ex_payload_i = '0;
        ex_mem_addr_i = '0;
        ex_mem_wdata_i = '0;
        idle_ex();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        data_rdata_i = '0;
        mem_allowin_i = 1'b1;
        #12;
        check_output("rst_req", {255'd0, data_req_o}, 256'd0);
        check_output("rst_valid", {255'd0, mem_valid_o}, 256'd0);
        check_output("rst_allowin", {255'd0, ex_allowin_o}, 256'd1);
        check_output("rst_payload", exmem_payload_o, 256'd0);
        check_output("rst_bus", {data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o}, 256'd0);
        check_output("rst_rdata", {224'd0, mem_rdata_o}, 256'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Load with a slow bus: two request cycles, data_ok three cycles after addr_ok.
        p = {8{32'hA0000001}};
        apply_stimulus(p, 1'b1, 4'd0, 32'h0000_1000, 32'd0, 1'b0);
        sb.push_back(mk(p, 32'hDEADBEEF, 1'b1));
        tick();
        idle_ex();
        #1;
        check_output("ld_req1", {data_req_o, data_wr_o, data_addr_o}, {223'd0, 1'b1, 1'b0, 32'h1000});
        check_output("ld_allowin1", {255'd0, ex_allowin_o}, 256'd0);
        tick();
        data_addr_ok_i = 1'b1;
        #1;
        check_output("ld_req2", {data_req_o, data_wr_o, data_addr_o}, {223'd0, 1'b1, 1'b0, 32'h1000});
        tick();
        data_addr_ok_i = 1'b0;
        #1;
        check_output("ld_wait_req", {255'd0, data_req_o}, 256'd0);
        check_output("ld_wait_allowin", {255'd0, ex_allowin_o}, 256'd0);
        tick();
        tick();
        data_data_ok_i = 1'b1;
        data_rdata_i = 32'hDEADBEEF;
        #1;
        check_output("ld_not_yet_valid", {255'd0, mem_valid_o}, 256'd0);
        tick();
        data_data_ok_i = 1'b0;
        data_rdata_i = 32'h0;
        #1;
        check_output("ld_valid", {224'd0, mem_valid_o, mem_rdata_o}, {223'd0, 1'b1, 32'hDEADBEEF});
        tick();

        // Five back-to-back non-memory instructions.
        for (int i = 0; i < 5; i++) begin
            k = 32'hB000_0000 + i;
            p = {8{k}};
            apply_stimulus(p, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            sb.push_back(mk(p, 32'd0, 1'b0));
            #1;
            check_output("b2b_allowin", {255'd0, ex_allowin_o}, 256'd1);
            if (i > 0) check_output("b2b_valid", {254'd0, mem_valid_o, data_req_o}, 256'd2);
            tick();
        end
        idle_ex();
        #1;
        check_output("b2b_last_valid", {254'd0, mem_valid_o, data_req_o}, 256'd2);
        tick();
        check_output("b2b_drained", {255'd0, mem_valid_o}, 256'd0);

        // Access carrying an exception never reaches the bus.
        p = {8{32'hC0000003}};
        apply_stimulus(p, 1'b1, 4'd0, 32'h0000_0040, 32'd0, 1'b1);
        sb.push_back(mk(p, 32'd0, 1'b0));
        tick();
        idle_ex();
        #1;
        check_output("excep_no_req", {254'd0, mem_valid_o, data_req_o}, 256'd2);
        tick();

        // Flush while WAIT: the stale data_ok must be swallowed.
        apply_stimulus({8{32'hD0000004}}, 1'b1, 4'd0, 32'h0000_3000, 32'd0, 1'b0);
        tick();
        idle_ex();
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        excep_flush_i = 1'b1;
        tick();
        excep_flush_i = 1'b0;
        p = {8{32'hD0000005}};
        apply_stimulus(p, 1'b1, 4'd0, 32'h0000_2000, 32'd0, 1'b0);
        sb.push_back(mk(p, 32'h22222222, 1'b1));
        #1;
        check_output("fl_allowin", {255'd0, ex_allowin_o}, 256'd1);
        tick();
        idle_ex();
        #1;
        check_output("fl_req_blocked1", {data_req_o, data_addr_o}, {223'd0, 1'b0, 32'h2000});
        tick();
        check_output("fl_req_blocked2", {255'd0, data_req_o}, 256'd0);
        data_data_ok_i = 1'b1;
        data_rdata_i = 32'h11111111;
        #1;
        check_output("fl_req_blocked3", {255'd0, data_req_o}, 256'd0);
        tick();
        data_data_ok_i = 1'b0;
        data_rdata_i = 32'h0;
        #1;
        check_output("fl_req_released", {255'd0, data_req_o}, 256'd1);
        check_output("fl_stale_discarded", {224'd0, mem_rdata_o}, {224'd0, 32'hDEADBEEF});
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        tick();
        data_data_ok_i = 1'b1;
        data_rdata_i = 32'h22222222;
        tick();
        data_data_ok_i = 1'b0;
        data_rdata_i = 32'h0;
        #1;
        check_output("fl_new_data", {224'd0, mem_valid_o, mem_rdata_o}, {223'd0, 1'b1, 32'h22222222});
        tick();

        // Flush in REQ without addr_ok: no cancel, the next store issues at once.
        apply_stimulus({8{32'hE0000006}}, 1'b1, 4'd0, 32'h0000_4000, 32'd0, 1'b0);
        tick();
        idle_ex();
        #1;
        check_output("rq_req", {255'd0, data_req_o}, 256'd1);
        excep_flush_i = 1'b1;
        tick();
        excep_flush_i = 1'b0;
        #1;
        check_output("rq_withdrawn", {254'd0, data_req_o, ex_allowin_o}, 256'd1);
        p = {8{32'hE0000007}};
        apply_stimulus(p, 1'b1, 4'b0011, 32'h0000_5000, 32'h0000_ABCD, 1'b0);
        sb.push_back(mk(p, 32'd0, 1'b0));
        tick();
        idle_ex();
        #1;
        check_output("st_req", {data_req_o, data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o},
                     {186'd0, 1'b1, 1'b1, 4'b0011, 32'h5000, 32'h0000ABCD});
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b1;
        tick();
        data_data_ok_i = 1'b0;
        #1;
        check_output("st_done", {255'd0, mem_valid_o}, 256'd1);
        tick();

        // MEM back-pressure: READY contents held stable.
        p = {8{32'hF0000008}};
        apply_stimulus(p, 1'b1, 4'd0, 32'h0000_6000, 32'd0, 1'b0);
        sb.push_back(mk(p, 32'h5A5A5A5A, 1'b1));
        tick();
        idle_ex();
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        mem_allowin_i = 1'b0;
        data_data_ok_i = 1'b1;
        data_rdata_i = 32'h5A5A5A5A;
        tick();
        data_data_ok_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_rdata_i = 32'h9999_0000 + i;
            #1;
            check_output("hold_ctrl", {254'd0, mem_valid_o, ex_allowin_o}, 256'd2);
            check_output("hold_payload", exmem_payload_o, p);
            check_output("hold_rdata", {224'd0, mem_rdata_o}, {224'd0, 32'h5A5A5A5A});
            tick();
        end
        mem_allowin_i = 1'b1;
        data_rdata_i = 32'h0;
        tick();

        // Asynchronous reset in WAIT, then a late data_ok that must be ignored.
        apply_stimulus({8{32'h12340009}}, 1'b1, 4'b1111, 32'h0000_7000, 32'h5555AAAA, 1'b0);
        tick();
        idle_ex();
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("ar_ctrl", {253'd0, data_req_o, mem_valid_o, ex_allowin_o}, 256'd1);
        check_output("ar_bus", {data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o}, 256'd0);
        check_output("ar_data", {exmem_payload_o[223:0], mem_rdata_o}, 256'd0);
        tick();
        rst_n = 1'b1;
        data_data_ok_i = 1'b1;
        data_rdata_i = 32'h77777777;
        tick();
        data_data_ok_i = 1'b0;
        data_rdata_i = 32'h0;
        #1;
        check_output("ar_late_ok", {222'd0, mem_valid_o, ex_allowin_o, mem_rdata_o}, {222'd0, 1'b0, 1'b1, 32'd0});
        tick();

        check_output("sb_empty", 256'(sb.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
